// File: rtl/id_hazard_if.sv
// Decode/issue handshake bundle between the ID stage and the hazard controller.
interface id_hazard_if;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic        id_rs_used;
  logic [4:0]  id_rt;
  logic        id_rt_used;
  logic [4:0]  id_rd;
  logic        id_reg_write;
  logic        id_sp_update;
  logic        ex_branch_taken;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic        wb_sp_we;
  logic        id_issue;
  logic        stall_ifid;
  logic        flush_ifid;
  logic        bubble_idex;
  logic [31:0] pending;

  modport master (
    output id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_rd, id_reg_write,
           id_sp_update, ex_branch_taken, wb_we, wb_reg, wb_sp_we,
    input  id_issue, stall_ifid, flush_ifid, bubble_idex, pending
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_rd, id_reg_write,
           id_sp_update, ex_branch_taken, wb_we, wb_reg, wb_sp_we,
    output id_issue, stall_ifid, flush_ifid, bubble_idex, pending
  );
endinterface

// File: rtl/id_hazard_ctrl.sv
// Scoreboard issue controller: holds decode on RAW/WAW/SP hazards and
// flushes the IF/ID register for a fixed window after a taken branch.
module id_hazard_ctrl #(
  parameter int SP_REG       = 29,
  parameter int FLUSH_CYCLES = 2,
  parameter bit HARDWIRED_R0 = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  id_hazard_if.slave bus
);
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES - 1);
  localparam logic [31:0]   SP_BIT   = 32'(1) << SP_REG;

  logic [31:0]   p;
  logic [31:0]   set_v;
  logic [31:0]   clr_v;
  logic [31:0]   p_next;
  logic [CW-1:0] cnt;
  logic          flushing;
  logic          hazard;
  logic          issue;

  assign flushing = bus.ex_branch_taken | (cnt != '0);

  // Hazard reads registered P only: a writeback this cycle unblocks next cycle.
  assign hazard = (bus.id_rs_used   & p[bus.id_rs])
                | (bus.id_rt_used   & p[bus.id_rt])
                | (bus.id_reg_write & p[bus.id_rd])
                | (bus.id_sp_update & p[SP_REG]);

  // Outputs are forced to their idle values while reset is held.
  assign issue          = ~rst & bus.id_valid & ~hazard & ~flushing;
  assign bus.id_issue   = issue;
  assign bus.stall_ifid = ~rst & bus.id_valid & hazard & ~flushing;
  assign bus.flush_ifid = ~rst & flushing;
  assign bus.bubble_idex = ~issue;
  assign bus.pending    = p;

  always_comb begin
    set_v = '0;
    clr_v = '0;
    if (bus.wb_we)                     clr_v = clr_v | (32'(1) << bus.wb_reg);
    if (bus.wb_sp_we)                  clr_v = clr_v | SP_BIT;
    if (issue && bus.id_reg_write)     set_v = set_v | (32'(1) << bus.id_rd);
    if (issue && bus.id_sp_update)     set_v = set_v | SP_BIT;
    if (HARDWIRED_R0)                  set_v[0] = 1'b0;
    // Set wins over a same-cycle clear of the same bit.
    p_next = (p & ~clr_v) | set_v;
    if (HARDWIRED_R0)                  p_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p   <= '0;
      cnt <= '0;
    end else begin
      p <= p_next;
      if (bus.ex_branch_taken)  cnt <= CNT_LOAD;
      else if (cnt != '0)       cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: scoreboard hazards, SP serialisation,
// branch flush window, async reset and hardwired R0.
module tb_id_hazard_ctrl;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  id_hazard_if bus0();
  id_hazard_if bus1();

  id_hazard_ctrl #(.SP_REG(29), .FLUSH_CYCLES(2), .HARDWIRED_R0(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  id_hazard_ctrl #(.SP_REG(29), .FLUSH_CYCLES(2), .HARDWIRED_R0(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle0();
    bus0.id_valid = 0; bus0.id_rs = 0; bus0.id_rs_used = 0; bus0.id_rt = 0;
    bus0.id_rt_used = 0; bus0.id_rd = 0; bus0.id_reg_write = 0; bus0.id_sp_update = 0;
    bus0.ex_branch_taken = 0; bus0.wb_we = 0; bus0.wb_reg = 0; bus0.wb_sp_we = 0;
  endtask

  task automatic idle1();
    bus1.id_valid = 0; bus1.id_rs = 0; bus1.id_rs_used = 0; bus1.id_rt = 0;
    bus1.id_rt_used = 0; bus1.id_rd = 0; bus1.id_reg_write = 0; bus1.id_sp_update = 0;
    bus1.ex_branch_taken = 0; bus1.wb_we = 0; bus1.wb_reg = 0; bus1.wb_sp_we = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle0(); idle1();
    bus0.id_valid = 1; bus0.id_rd = 4; bus0.id_reg_write = 1;
    #1;
    tests++; if (bus0.id_issue !== 1'b0) begin fails++; $display("FAIL reset_issue got %b exp 0", bus0.id_issue); end
    tests++; if (bus0.stall_ifid !== 1'b0) begin fails++; $display("FAIL reset_stall got %b exp 0", bus0.stall_ifid); end
    tests++; if (bus0.flush_ifid !== 1'b0) begin fails++; $display("FAIL reset_flush got %b exp 0", bus0.flush_ifid); end
    tests++; if (bus0.bubble_idex !== 1'b1) begin fails++; $display("FAIL reset_bubble got %b exp 1", bus0.bubble_idex); end
    cyc();
    tests++; if (bus0.pending !== 32'h0) begin fails++; $display("FAIL reset_pending got %h exp 0", bus0.pending); end
    rst = 0;
    idle0();
    cyc();
  endtask

  task automatic test_raw();
    idle0();
    bus0.id_valid = 1; bus0.id_rd = 5; bus0.id_reg_write = 1;
    #1;
    tests++; if (bus0.id_issue !== 1'b1) begin fails++; $display("FAIL raw_first_issue got %b exp 1", bus0.id_issue); end
    cyc();
    tests++; if (bus0.pending !== 32'h20) begin fails++; $display("FAIL raw_set got %h exp 00000020", bus0.pending); end
    bus0.id_rd = 0; bus0.id_reg_write = 0; bus0.id_rs = 5; bus0.id_rs_used = 1;
    #1;
    tests++; if (bus0.stall_ifid !== 1'b1) begin fails++; $display("FAIL raw_stall got %b exp 1", bus0.stall_ifid); end
    tests++; if (bus0.bubble_idex !== 1'b1) begin fails++; $display("FAIL raw_bubble got %b exp 1", bus0.bubble_idex); end
    for (int i = 0; i < 2; i++) begin
      cyc();
      tests++; if (bus0.stall_ifid !== 1'b1 || bus0.id_issue !== 1'b0)
        begin fails++; $display("FAIL raw_hold%0d stall %b issue %b exp 1/0", i, bus0.stall_ifid, bus0.id_issue); end
    end
    bus0.wb_we = 1; bus0.wb_reg = 5;
    #1;
    tests++; if (bus0.stall_ifid !== 1'b1) begin fails++; $display("FAIL raw_no_bypass got %b exp 1", bus0.stall_ifid); end
    cyc();
    bus0.wb_we = 0;
    #1;
    tests++; if (bus0.pending !== 32'h0) begin fails++; $display("FAIL raw_clear got %h exp 0", bus0.pending); end
    tests++; if (bus0.id_issue !== 1'b1 || bus0.stall_ifid !== 1'b0)
      begin fails++; $display("FAIL raw_release issue %b stall %b exp 1/0", bus0.id_issue, bus0.stall_ifid); end
    cyc();
    idle0();
  endtask

  task automatic test_sp();
    idle0();
    bus0.id_valid = 1; bus0.id_sp_update = 1;
    #1;
    tests++; if (bus0.id_issue !== 1'b1) begin fails++; $display("FAIL sp_push_issue got %b exp 1", bus0.id_issue); end
    cyc();
    tests++; if (bus0.pending !== 32'h2000_0000) begin fails++; $display("FAIL sp_push_set got %h exp 20000000", bus0.pending); end
    tests++; if (bus0.stall_ifid !== 1'b1) begin fails++; $display("FAIL sp_call_stall got %b exp 1", bus0.stall_ifid); end
    bus0.wb_sp_we = 1;
    cyc();
    bus0.wb_sp_we = 0;
    #1;
    tests++; if (bus0.pending !== 32'h0 || bus0.id_issue !== 1'b1)
      begin fails++; $display("FAIL sp_call_release pending %h issue %b exp 0/1", bus0.pending, bus0.id_issue); end
    cyc();
    idle0();
    bus0.wb_sp_we = 1;
    cyc();
    idle0();
    tests++; if (bus0.pending !== 32'h0) begin fails++; $display("FAIL sp_call_clear got %h exp 0", bus0.pending); end
    bus0.id_valid = 1; bus0.id_sp_update = 1; bus0.id_reg_write = 1; bus0.id_rd = 7;
    cyc();
    idle0();
    tests++; if (bus0.pending !== 32'h2000_0080) begin fails++; $display("FAIL sp_pop_set got %h exp 20000080", bus0.pending); end
    bus0.wb_sp_we = 1;
    cyc();
    idle0();
    tests++; if (bus0.pending !== 32'h80) begin fails++; $display("FAIL sp_pop_sp_first got %h exp 00000080", bus0.pending); end
    bus0.wb_we = 1; bus0.wb_reg = 7;
    cyc();
    idle0();
    tests++; if (bus0.pending !== 32'h0) begin fails++; $display("FAIL sp_pop_rd_clear got %h exp 0", bus0.pending); end
  endtask

  task automatic test_collision();
    idle0();
    bus0.wb_we = 1; bus0.wb_reg = 3;
    bus0.id_valid = 1; bus0.id_rd = 3; bus0.id_reg_write = 1;
    #1;
    tests++; if (bus0.id_issue !== 1'b1) begin fails++; $display("FAIL coll_issue got %b exp 1", bus0.id_issue); end
    cyc();
    idle0();
    tests++; if (bus0.pending !== 32'h8) begin fails++; $display("FAIL coll_set_wins got %h exp 00000008", bus0.pending); end
    bus0.wb_we = 1; bus0.wb_reg = 3;
    cyc();
    idle0();
  endtask

  task automatic test_flush();
    idle0();
    bus0.id_valid = 1; bus0.id_rd = 5; bus0.id_reg_write = 1;
    cyc();
    bus0.id_rd = 0; bus0.id_reg_write = 0; bus0.id_rs = 5; bus0.id_rs_used = 1;
    bus0.ex_branch_taken = 1;
    #1;
    tests++; if (bus0.flush_ifid !== 1'b1 || bus0.stall_ifid !== 1'b0 || bus0.id_issue !== 1'b0 || bus0.bubble_idex !== 1'b1)
      begin fails++; $display("FAIL flush_c0 flush %b stall %b issue %b bubble %b exp 1/0/0/1",
        bus0.flush_ifid, bus0.stall_ifid, bus0.id_issue, bus0.bubble_idex); end
    cyc();
    bus0.ex_branch_taken = 0;
    #1;
    tests++; if (bus0.flush_ifid !== 1'b1 || bus0.stall_ifid !== 1'b0)
      begin fails++; $display("FAIL flush_c1 flush %b stall %b exp 1/0", bus0.flush_ifid, bus0.stall_ifid); end
    cyc();
    tests++; if (bus0.flush_ifid !== 1'b0 || bus0.stall_ifid !== 1'b1)
      begin fails++; $display("FAIL flush_c2 flush %b stall %b exp 0/1", bus0.flush_ifid, bus0.stall_ifid); end
    tests++; if (bus0.pending !== 32'h20) begin fails++; $display("FAIL flush_p_kept got %h exp 00000020", bus0.pending); end
    // Issuable writer in ID during the window must be dropped.
    bus0.id_rs_used = 0; bus0.id_rd = 9; bus0.id_reg_write = 1;
    bus0.ex_branch_taken = 1;
    cyc();
    tests++; if (bus0.flush_ifid !== 1'b1) begin fails++; $display("FAIL flush_ext_c1 got %b exp 1", bus0.flush_ifid); end
    cyc();
    bus0.ex_branch_taken = 0;
    #1;
    tests++; if (bus0.flush_ifid !== 1'b1 || bus0.id_issue !== 1'b0)
      begin fails++; $display("FAIL flush_ext_c2 flush %b issue %b exp 1/0", bus0.flush_ifid, bus0.id_issue); end
    cyc();
    tests++; if (bus0.flush_ifid !== 1'b0 || bus0.id_issue !== 1'b1)
      begin fails++; $display("FAIL flush_ext_c3 flush %b issue %b exp 0/1", bus0.flush_ifid, bus0.id_issue); end
    tests++; if (bus0.pending !== 32'h20) begin fails++; $display("FAIL flush_drop got %h exp 00000020", bus0.pending); end
    idle0();
    bus0.id_rs = 5; bus0.id_rs_used = 1;
    #1;
    tests++; if (bus0.stall_ifid !== 1'b0 || bus0.bubble_idex !== 1'b1)
      begin fails++; $display("FAIL invalid_ignored stall %b bubble %b exp 0/1", bus0.stall_ifid, bus0.bubble_idex); end
    bus0.wb_we = 1; bus0.wb_reg = 5;
    cyc();
    idle0();
    tests++; if (bus0.pending !== 32'h0) begin fails++; $display("FAIL flush_cleanup got %h exp 0", bus0.pending); end
  endtask

  task automatic test_reset_mid();
    idle0();
    bus0.id_valid = 1; bus0.id_rd = 5; bus0.id_reg_write = 1;
    cyc();
    bus0.id_rd = 7;
    cyc();
    idle0();
    tests++; if (bus0.pending !== 32'hA0) begin fails++; $display("FAIL rmid_setup got %h exp 000000a0", bus0.pending); end
    bus0.ex_branch_taken = 1;
    cyc();
    bus0.ex_branch_taken = 0;
    #2;
    rst = 1;
    #1;
    tests++; if (bus0.pending !== 32'h0 || bus0.flush_ifid !== 1'b0 || bus0.bubble_idex !== 1'b1)
      begin fails++; $display("FAIL rmid_async pending %h flush %b bubble %b exp 0/0/1",
        bus0.pending, bus0.flush_ifid, bus0.bubble_idex); end
    cyc();
    rst = 0;
    bus0.id_valid = 1; bus0.id_rs = 5; bus0.id_rs_used = 1; bus0.id_rt = 7; bus0.id_rt_used = 1;
    #1;
    tests++; if (bus0.id_issue !== 1'b1 || bus0.stall_ifid !== 1'b0 || bus0.flush_ifid !== 1'b0)
      begin fails++; $display("FAIL rmid_first issue %b stall %b flush %b exp 1/0/0",
        bus0.id_issue, bus0.stall_ifid, bus0.flush_ifid); end
    cyc();
    idle0();
  endtask

  task automatic test_r0();
    idle1();
    bus1.id_valid = 1; bus1.id_rd = 0; bus1.id_reg_write = 1;
    #1;
    tests++; if (bus1.id_issue !== 1'b1) begin fails++; $display("FAIL r0_write_issue got %b exp 1", bus1.id_issue); end
    cyc();
    tests++; if (bus1.pending !== 32'h0) begin fails++; $display("FAIL r0_never_pending got %h exp 0", bus1.pending); end
    bus1.id_reg_write = 0; bus1.id_rs = 0; bus1.id_rs_used = 1;
    #1;
    tests++; if (bus1.id_issue !== 1'b1 || bus1.stall_ifid !== 1'b0)
      begin fails++; $display("FAIL r0_read issue %b stall %b exp 1/0", bus1.id_issue, bus1.stall_ifid); end
    cyc();
    idle1();
    // Without the hardwired option R0 is an ordinary register.
    idle0();
    bus0.id_valid = 1; bus0.id_rd = 0; bus0.id_reg_write = 1;
    cyc();
    idle0();
    tests++; if (bus0.pending !== 32'h1) begin fails++; $display("FAIL r0_soft_set got %h exp 00000001", bus0.pending); end
    bus0.wb_we = 1; bus0.wb_reg = 0;
    cyc();
    idle0();
    tests++; if (bus0.pending !== 32'h0) begin fails++; $display("FAIL r0_soft_clear got %h exp 0", bus0.pending); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_raw();
    test_sp();
    test_collision();
    test_flush();
    test_reset_mid();
    test_r0();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
